wt_cache: RTL and testbench

WT_CACHE -- requirements
Module: wt_cache

---
 rtl/lc3b_types.sv | 8 +
 rtl/wt_cache_array.sv | 38 +++
 rtl/wt_cache.sv | 78 +++++++
 tb/tb_wt_cache.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/mask types plus cache line type, offset width and cache FSM states.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef logic [127:0] lc3b_cache_line;
  localparam int CACHE_OFFSET_W = 4;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} wt_state_e;
endpackage

// File: rtl/wt_cache_array.sv
// wt_cache_array: direct-mapped valid/tag/data storage; only valid bits are cleared by rst.
module wt_cache_array import lc3b_types::*; #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     index,
  input  logic                 fill,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [127:0]         fill_line,
  input  logic                 wr_word,
  input  logic [2:0]           word_sel,
  input  logic [15:0]          wdata,
  input  logic [1:0]           wmask,
  output logic                 valid,
  output logic [TAG_W-1:0]     tag,
  output logic [127:0]         line
);
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0] tags [NUM_SETS];
  lc3b_cache_line data [NUM_SETS];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else if (fill) valid_q[index] <= 1'b1;
  always_ff @(posedge clk)
    if (fill) begin
      tags[index] <= fill_tag;
      data[index] <= fill_line;
    end else if (wr_word) begin
      for (int b = 0; b < 2; b++)
        if (wmask[b]) data[index][{word_sel, b[0], 3'b000} +: 8] <= wdata[b*8 +: 8];
    end
  assign valid = valid_q[index];
  assign tag = tags[index];
  assign line = data[index];
endmodule

// File: rtl/wt_cache.sv
// wt_cache: direct-mapped write-through, no-allocate cache for the LC-3b memory port.
// Define WT_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module wt_cache import lc3b_types::*; #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_wdata,
  output logic [1:0]   pmem_byte_enable,
  input  logic [127:0] pmem_rdata,
`ifdef WT_CACHE_STATS_EN
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`else
  input  logic         pmem_resp
`endif
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - CACHE_OFFSET_W - IDX_W;
  wt_state_e state;
  logic valid, hit, rd_hit, rd_miss;
  logic [TAG_W-1:0] tag;
  lc3b_cache_line line;
  lc3b_word word;
  wt_cache_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk(clk),
    .rst(rst),
    .index(mem_address[CACHE_OFFSET_W +: IDX_W]),
    .fill(state == FILL && pmem_resp),
    .fill_tag(mem_address[15 -: TAG_W]),
    .fill_line(pmem_rdata),
    .wr_word(state == WRITE && pmem_resp && hit),
    .word_sel(mem_address[3:1]),
    .wdata(mem_wdata),
    .wmask(mem_byte_enable),
    .valid(valid),
    .tag(tag),
    .line(line)
  );
  assign hit = valid && tag == mem_address[15 -: TAG_W];
  assign word = line[{mem_address[3:1], 4'b0000} +: 16];
  assign rd_hit = state == IDLE && mem_read && !mem_write && hit;
  assign rd_miss = state == IDLE && mem_read && !mem_write && !hit;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= (state == IDLE) ? (mem_write ? WRITE : rd_miss ? FILL : IDLE)
                                  : (pmem_resp ? IDLE : state);
  always_comb begin
    mem_resp = rd_hit || (state == WRITE && pmem_resp);
    mem_rdata = rd_hit ? word : 16'h0000;
    pmem_read = state == FILL;
    pmem_write = state == WRITE;
    pmem_address = pmem_read ? {mem_address[15:4], 4'b0000} : pmem_write ? mem_address : 16'h0000;
    pmem_wdata = pmem_write ? mem_wdata : 16'h0000;
    pmem_byte_enable = pmem_write ? mem_byte_enable : 2'b00;
  end
`ifdef WT_CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (rd_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_wt_cache.sv
// tb_wt_cache: directed and randomized checks of wt_cache against a line-presence and memory model.
module tb_wt_cache;
  localparam int NS = 8;
  logic clk = 0, rst = 1;
  logic [15:0] mem_address = '0, mem_wdata = '0, mem_rdata, pmem_address, pmem_wdata;
  logic mem_read = 0, mem_write = 0, mem_resp, pmem_read, pmem_write, pmem_resp = 0;
  logic [1:0] mem_byte_enable = '0, pmem_byte_enable;
  logic [127:0] pmem_rdata = '0;
`ifdef WT_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  int checks = 0, failures = 0, exp_hits = 0, exp_miss = 0;
  logic [15:0] mem [512];
  int model_line [NS];
  logic [15:0] got;

  always #5 clk = ~clk;

  wt_cache #(.NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable), .pmem_rdata(pmem_rdata),
`ifdef WT_CACHE_STATS_EN
    .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
`else
    .pmem_resp(pmem_resp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = mem[{a[9:4], 3'(w)}];
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) model_line[i] = -1;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic do_read(input logic [15:0] a, input int dly, output logic [15:0] rd);
    int d, cyc, fills, idx;
    bit miss, done;
    d = dly < 0 ? int'($urandom_range(0, 3)) : dly;
    idx = (int'(a) / 16) % NS;
    miss = model_line[idx] != int'(a) / 16;
    model_line[idx] = int'(a) / 16;
    exp_hits++;
    if (miss) exp_miss++;
    mem_address = a;
    mem_read = 1;
    cyc = 0; fills = 0; done = 0; rd = 'x;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        rd = mem_rdata;
        chk("rd_data", mem_rdata, mem[a[9:1]]);
        chk("rd_latency", cyc, miss ? d + 3 : 1);
        chk("rd_fill_cycles", fills, miss ? d + 1 : 0);
        chk("rd_no_pmem_with_resp", {pmem_read, pmem_write}, 0);
        done = 1;
      end else if (pmem_read) begin
        if (fills == 0) chk("fill_addr", pmem_address, {a[15:4], 4'b0000});
        if (fills == d) begin
          pmem_resp = 1;
          pmem_rdata = line_of(a);
        end
        fills++;
      end
      @(posedge clk);
      #1 pmem_resp = 0;
    end
    mem_read = 0;
    if (!done) chk("rd_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be, input bit both);
    int d, cyc;
    bit done;
    d = $urandom_range(0, 3);
    mem_address = a;
    mem_wdata = wd;
    mem_byte_enable = be;
    mem_write = 1;
    mem_read = both;
    cyc = 0; done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!pmem_write) chk("wr_no_early_resp", {mem_resp, pmem_read}, 0);
      else begin
        if (cyc == 2) chk("wr_pmem", {pmem_address, pmem_wdata}, {a, wd});
        if (cyc == 2) chk("wr_be", pmem_byte_enable, be);
        if (cyc == d + 2) begin
          pmem_resp = 1;
          #1 chk("wr_resp", mem_resp, 1);
          if (be[0]) mem[a[9:1]][7:0] = wd[7:0];
          if (be[1]) mem[a[9:1]][15:8] = wd[15:8];
          done = 1;
        end else chk("wr_resp_early", mem_resp, 0);
      end
      @(posedge clk);
      #1 pmem_resp = 0;
    end
    mem_write = 0;
    mem_read = 0;
    if (!done) chk("wr_timeout", 0, 1);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    model_reset();
    #1;
    chk("reset_outputs", {mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address}, 0);
    chk("reset_outputs2", {pmem_wdata, pmem_byte_enable}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // first fill of line 0x0040 with word 1 = 0x1234
    mem[16'h0042 >> 1] = 16'h1234;
    do_read(16'h0040, 2, got);
    do_read(16'h0042, -1, got);
    chk("req029_hit_data", got, 16'h1234);
    do_write(16'h0042, 16'hABCD, 2'b10, 1);
    do_read(16'h0042, -1, got);
    chk("req030_merge", got, 16'hAB34);
    do_write(16'h0046, 16'h5555, 2'b00, 0);
    do_read(16'h0046, -1, got);
    do_write(16'h0100, 16'hBEEF, 2'b11, 0);
    do_read(16'h0100, -1, got);
    chk("req031_no_allocate", got, 16'hBEEF);
    do_read(16'h00C0, -1, got);
    do_read(16'h0040, -1, got);
    // reset in the middle of a fill
    mem_address = 16'h0080;
    mem_read = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    chk("req033_fill_seen", seen, 1);
    #2 rst = 1;
    #1 chk("req033_async_drop", {pmem_read, mem_resp, pmem_address}, 0);
    mem_read = 0;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    do_read(16'h0080, -1, got);
    do_read(16'h0080, -1, got);
    do_read(16'h0082, -1, got);
`ifdef WT_CACHE_STATS_EN
    chk("stats_miss1", miss_count, 1);
    chk("stats_hit3", hit_count, 3);
`endif
    for (int n = 0; n < 120; n++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 1023)) & 16'hFFFE;
      if ($urandom_range(0, 9) < 4) do_write(a, 16'($urandom), 2'($urandom), 1'($urandom));
      else do_read(a, -1, got);
    end
`ifdef WT_CACHE_STATS_EN
    chk("stats_rand_miss", miss_count, exp_miss);
    chk("stats_rand_hit", hit_count, exp_hits);
    do_read(16'h0080, -1, got);
    mem_address = 16'h0080;
    mem_read = 1;
    repeat (65540) @(posedge clk);
    #1 chk("stats_hit_sat", hit_count, 16'hFFFF);
    mem_read = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
